regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Two-write, two-read register file with a debug read port and a DEPTH-cycle clear sequence.
// Define RF_BYPASS_EN to forward same-cycle write data onto rd1/rd2.
module regfile_mp #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] wa0,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data,
  output logic          busy
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic {StIdle, StClear} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cptr_q, cptr_d;
  logic [DW-1:0] mem [DEPTH];
  logic          wr0_en, wr1_en;
  logic          zero_ra1, zero_ra2, zero_dbg;

  assign busy = (state_q == StClear);

  // A clear request in the same cycle as a write wins and the write is dropped.
  assign wr0_en = (state_q == StIdle) && !clr && we0 && !((ZERO_R0 != 0) && (wa0 == '0));
  assign wr1_en = (state_q == StIdle) && !clr && we1 && !((ZERO_R0 != 0) && (wa1 == '0));

  assign zero_ra1 = (ZERO_R0 != 0) && (ra1 == '0);
  assign zero_ra2 = (ZERO_R0 != 0) && (ra2 == '0);
  assign zero_dbg = (ZERO_R0 != 0) && (dbg_sel == '0);

  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StClear;
          cptr_d  = '0;
        end
      end
      StClear: begin
        if (clr) begin
          cptr_d = '0;
        end else if (cptr_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
        end else begin
          cptr_d = cptr_q + AW'(1);
        end
      end
      default: begin
        state_d = StClear;
        cptr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
    end
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
    end else if (state_q == StClear) begin
      mem[cptr_q] <= '0;
    end else begin
      if (wr0_en) mem[wa0] <= wd0;
      if (wr1_en) mem[wa1] <= wd1;
    end
  end

  always_comb begin
    rd1      = mem[ra1];
    rd2      = mem[ra2];
    dbg_data = mem[dbg_sel];
`ifdef RF_BYPASS_EN
    if (wr0_en && (wa0 == ra1)) rd1 = wd0;
    if (wr1_en && (wa1 == ra1)) rd1 = wd1;
    if (wr0_en && (wa0 == ra2)) rd2 = wd0;
    if (wr1_en && (wa1 == ra2)) rd2 = wd1;
`endif
    if (busy || zero_ra1) rd1 = '0;
    if (busy || zero_ra2) rd2 = '0;
    if (busy || zero_dbg) dbg_data = '0;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expected values are queued as stimulus is driven
// and popped when the matching DUT output is sampled.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst, clr, we0, we1;
  logic [AW-1:0] wa0, wa1, ra1, ra2, dbg_sel;
  logic [DW-1:0] wd0, wd1, rd1, rd2, dbg_data;
  logic          busy;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            n_pass = 0;
  int            n_total = 0;

  regfile_mp #(.DW(DW), .AW(AW), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles starting at the current sample; optionally injects an action.
  // kind 1: write entry 3 at cycle act; kind 2: clr pulse at cycle act.
  task automatic busy_run(input int act, input int kind, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == act) begin
        if (kind == 1) begin we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_0033; end
        else clr = 1'b1;
      end
      tick();
      we0 = 1'b0;
      clr = 1'b0;
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic [DW-1:0] e;
    rst = 1'b1;
    repeat (3) tick();
    ra1 = 5'd9; ra2 = 5'd17; dbg_sel = 5'd4;
    #1;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    n_total++;
    if ({31'd0, busy} !== e) $display("FAIL reset_busy: got %0d want %0d", busy, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if ((rd1 | rd2 | dbg_data) !== e) $display("FAIL reset_reads: got %h/%h/%h want 0", rd1, rd2, dbg_data);
    else n_pass++;
    rst = 1'b0;
    exp_q.push_back(32'd32);
    busy_run(0, 0, cnt);
    e = exp_q.pop_front();
    n_total++;
    if (cnt !== int'(e)) $display("FAIL reset_busy_len: got %0d want %0d", cnt, e);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dbg_sel = AW'(i);
      exp_q.push_back(model[i]);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if (dbg_data !== e) $display("FAIL reset_sweep[%0d]: got %h want %h", i, dbg_data, e);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] e;
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd5; wa1 = 5'd5;
    wd0 = 32'h1111_1111; wd1 = 32'h2222_2222;
    model[5] = wd1;
    exp_q.push_back(model[5]);
    exp_q.push_back(model[5]);
    tick();
    we0 = 1'b0; we1 = 1'b0; ra1 = 5'd5; dbg_sel = 5'd5;
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (rd1 !== e) $display("FAIL collision_rd1: got %h want %h", rd1, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (dbg_data !== e) $display("FAIL collision_dbg: got %h want %h", dbg_data, e);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] e;
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    tick();
    we0 = 1'b0; ra1 = 5'd0; dbg_sel = 5'd0;
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (rd1 !== e) $display("FAIL zero_rd1: got %h want %h", rd1, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (dbg_data !== e) $display("FAIL zero_dbg: got %h want %h", dbg_data, e);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [DW-1:0] e;
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hCAFE_F00D; ra2 = 5'd7; dbg_sel = 5'd7;
`ifdef RF_BYPASS_EN
    exp_q.push_back(32'hCAFE_F00D);
`else
    exp_q.push_back(model[7]);
`endif
    exp_q.push_back(model[7]);
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (rd2 !== e) $display("FAIL bypass_rd2: got %h want %h", rd2, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (dbg_data !== e) $display("FAIL bypass_dbg: got %h want %h", dbg_data, e);
    else n_pass++;
    model[7] = 32'hCAFE_F00D;
    exp_q.push_back(model[7]);
    tick();
    we0 = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (rd2 !== e) $display("FAIL bypass_after: got %h want %h", rd2, e);
    else n_pass++;
  endtask

  task automatic test_soft_clear();
    int cnt;
    logic [DW-1:0] e;
    for (int i = 1; i < DEPTH; i++) begin
      we1 = 1'b1; wa1 = AW'(i); wd1 = DW'(i);
      model[i] = DW'(i);
      tick();
    end
    we1 = 1'b0; ra1 = 5'd31; ra2 = 5'd12;
    exp_q.push_back(model[31]);
    exp_q.push_back(model[12]);
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (rd1 !== e) $display("FAIL fill_rd1: got %h want %h", rd1, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_total++;
    if (rd2 !== e) $display("FAIL fill_rd2: got %h want %h", rd2, e);
    else n_pass++;
    clr = 1'b1;
    tick();
    clr = 1'b0; dbg_sel = 5'd31;
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front();
    n_total++;
    if ((rd1 | rd2 | dbg_data) !== e) $display("FAIL busy_reads: got %h/%h/%h want 0", rd1, rd2, dbg_data);
    else n_pass++;
    exp_q.push_back(32'd32);
    busy_run(10, 1, cnt);
    e = exp_q.pop_front();
    n_total++;
    if (cnt !== int'(e)) $display("FAIL clear_len: got %0d want %0d", cnt, e);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dbg_sel = AW'(i); ra1 = AW'(i);
      exp_q.push_back(model[i]);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if ((rd1 | dbg_data) !== e) $display("FAIL clear_sweep[%0d]: got %h/%h want %h", i, rd1, dbg_data, e);
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    int cnt;
    logic [DW-1:0] e;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0099;
    tick();
    we0 = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.push_back(32'd52);
    busy_run(20, 2, cnt);
    e = exp_q.pop_front();
    n_total++;
    if (cnt !== int'(e)) $display("FAIL restart_len: got %0d want %0d", cnt, e);
    else n_pass++;
    ra1 = 5'd9;
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front();
    n_total++;
    if (rd1 !== e) $display("FAIL restart_cleared: got %h want %h", rd1, e);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    ra1 = '0; ra2 = '0; dbg_sel = '0;
    test_reset();
    test_collision();
    test_zero_reg();
    test_bypass();
    test_soft_clear();
    test_restart();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
